// File: rtl/ring_keypad_scanner.sv
// ring_keypad_scanner
//
// Scans a keypad matrix using the one-hot phase of a ring counter as the
// column drive. Each full rotation of the ring (columns 0..WIDTH-1 in order)
// forms one scan frame. The frame is classified as NONE / SINGLE(code) / MULTI.
// A frame-level debouncer accepts a key after DEBOUNCE identical SINGLE frames
// and considers it released after DEBOUNCE empty frames. Frames with two or
// more hits (possible ghosting) never produce a key. Accepted keys are
// presented through a valid/ready handshake.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-low
//   count      one-hot column select from the ring counter (WIDTH bits)
//   row_in     synchronised row sense for the driven column (ROWS bits)
//   key_ready  downstream accepts the presented key this cycle
//   key_valid  key_code holds an unconsumed key
//   key_code   row*WIDTH + col of the accepted key (CW bits)
//   overrun    one-cycle pulse: a new key overwrote an unconsumed one
//   illegal    one-cycle pulse: count was not one-hot on the previous cycle

module ring_keypad_scanner #(
  parameter int WIDTH    = 4,
  parameter int ROWS     = 4,
  parameter int DEBOUNCE = 4,
  parameter int CW       = $clog2(WIDTH * ROWS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count,
  input  logic [ROWS-1:0]  row_in,
  input  logic             key_ready,
  output logic             key_valid,
  output logic [CW-1:0]    key_code,
  output logic             overrun,
  output logic             illegal
);

  // Column index width (at least one bit so a single-column ring still works)
  localparam int CLW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // Debounce counter width: must be able to hold the value DEBOUNCE itself
  localparam int SW  = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    IDLE,
    DEB,
    HELD
  } state_t;

  state_t         state;
  state_t         nextState;

  // Frame accumulator: expected next column, saturating hit count (0/1/2+)
  // and the code of the first hit seen in the frame so far.
  logic [CLW-1:0] expCol;
  logic [1:0]     accHits;
  logic [CW-1:0]  accCode;

  // Column decode of count
  logic [1:0]     colOnes;
  logic [CLW-1:0] colIdx;
  logic           isOneHot;

  // Hits contributed by the current sample
  logic [1:0]     rowHits;
  logic [CW-1:0]  sampleCode;

  // Sample classification and merged frame totals
  logic           inOrder;
  logic           restart;
  logic           frameEnd;
  logic [1:0]     baseHits;
  logic [1:0]     mergedHits;
  logic [CW-1:0]  mergedCode;
  logic           frameNone;
  logic           frameSingle;
  logic           frameMulti;

  // Debouncer datapath
  logic [CW-1:0]  cand;
  logic [CW-1:0]  nextCand;
  logic [SW-1:0]  stab;
  logic [SW-1:0]  nextStab;
  logic [SW-1:0]  rel;
  logic [SW-1:0]  nextRel;
  logic           stabDone;
  logic           relDone;
  logic           acceptKey;

  // Find which column is driven and whether exactly one bit of count is set.
  // The hit counter saturates at 2 so "more than one" needs no wide adder.
  always_comb begin
    colOnes = 2'd0;
    colIdx  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (count[i]) begin
        colIdx  = CLW'(i);
        colOnes = (colOnes == 2'd0) ? 2'd1 : 2'd2;
      end
    end
    isOneHot = (colOnes == 2'd1);
  end

  // Count the row hits in this sample and remember the code of a hit. The
  // code only matters when the sample has exactly one hit.
  always_comb begin
    rowHits    = 2'd0;
    sampleCode = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (row_in[r]) begin
        rowHits    = (rowHits == 2'd0) ? 2'd1 : 2'd2;
        sampleCode = CW'(r * WIDTH) + CW'(colIdx);
      end
    end
  end

  // Classify the sample against the expected column and merge its hits with
  // the frame accumulated so far. A restart (out-of-order column 0) begins a
  // fresh frame, so it merges with an empty accumulator.
  always_comb begin
    inOrder  = isOneHot && (colIdx == expCol);
    restart  = isOneHot && !inOrder && (colIdx == '0);
    frameEnd = inOrder && (colIdx == CLW'(WIDTH - 1));
    baseHits = inOrder ? accHits : 2'd0;

    mergedHits = 2'd2;
    mergedCode = accCode;
    if (baseHits == 2'd0) begin
      mergedHits = rowHits;
      mergedCode = sampleCode;
    end else if (baseHits == 2'd1) begin
      mergedHits = (rowHits == 2'd0) ? 2'd1 : 2'd2;
      mergedCode = accCode;
    end

    frameNone   = frameEnd && (mergedHits == 2'd0);
    frameSingle = frameEnd && (mergedHits == 2'd1);
    frameMulti  = frameEnd && (mergedHits == 2'd2);
  end

  // Frame accumulator. Anything that breaks the in-order rotation throws the
  // partial frame away; a completed frame clears itself for the next one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      expCol  <= '0;
      accHits <= 2'd0;
      accCode <= '0;
      illegal <= 1'b0;
    end else begin
      illegal <= !isOneHot;
      if (!isOneHot) begin
        expCol  <= '0;
        accHits <= 2'd0;
        accCode <= '0;
      end else if (inOrder) begin
        if (frameEnd) begin
          expCol  <= '0;
          accHits <= 2'd0;
          accCode <= '0;
        end else begin
          expCol  <= expCol + CLW'(1);
          accHits <= mergedHits;
          accCode <= mergedCode;
        end
      end else if (restart) begin
        expCol  <= CLW'(1);
        accHits <= mergedHits;
        accCode <= mergedCode;
      end else begin
        expCol  <= '0;
        accHits <= 2'd0;
        accCode <= '0;
      end
    end
  end

  // Debouncer state register together with its candidate and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cand  <= '0;
      stab  <= '0;
      rel   <= '0;
    end else begin
      state <= nextState;
      cand  <= nextCand;
      stab  <= nextStab;
      rel   <= nextRel;
    end
  end

  // "This frame completes the count" flags, shared by next-state and output
  assign stabDone = ((stab + SW'(1)) == SW'(DEBOUNCE));
  assign relDone  = ((rel + SW'(1)) == SW'(DEBOUNCE));

  // Next-state logic. Only frame results move the debouncer; samples in the
  // middle of a frame leave it untouched.
  always_comb begin
    nextState = state;
    nextCand  = cand;
    nextStab  = stab;
    nextRel   = rel;
    unique case (state)
      IDLE: begin
        if (frameSingle) begin
          nextCand = mergedCode;
          nextStab = SW'(1);
          if (DEBOUNCE == 1) begin
            nextState = HELD;
            nextRel   = '0;
          end else begin
            nextState = DEB;
          end
        end
      end
      DEB: begin
        if (frameSingle) begin
          if (mergedCode == cand) begin
            if (stabDone) begin
              nextState = HELD;
              nextRel   = '0;
            end else begin
              nextStab = stab + SW'(1);
            end
          end else begin
            nextCand = mergedCode;
            nextStab = SW'(1);
          end
        end else if (frameNone || frameMulti) begin
          nextState = IDLE;
          nextStab  = '0;
        end
      end
      HELD: begin
        if (frameNone) begin
          if (relDone) begin
            nextState = IDLE;
            nextRel   = '0;
          end else begin
            nextRel = rel + SW'(1);
          end
        end else if (frameSingle || frameMulti) begin
          nextRel = '0;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Output decode: a key is accepted on the frame that takes the debouncer
  // into HELD. In DEB the merged code equals the candidate on that frame.
  always_comb begin
    acceptKey = 1'b0;
    if (frameSingle) begin
      if (state == IDLE && DEBOUNCE == 1) begin
        acceptKey = 1'b1;
      end else if (state == DEB && mergedCode == cand && stabDone) begin
        acceptKey = 1'b1;
      end
    end
  end

  // Key handshake register. An accept always wins over a transfer so a key
  // arriving in the same cycle as the previous one leaves keeps key_valid
  // high; overrun only fires when the old key was not being taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (acceptKey) begin
        key_valid <= 1'b1;
        key_code  <= mergedCode;
        overrun   <= key_valid && !key_ready;
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule
